// File: rtl/fsm_ctrl_pkg.sv
// Shared opcode constants and FSM state type for the Fibonacci control unit.
package fsm_ctrl_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ALU1 = 3'b001;
  localparam logic [2:0] OP_ALU2 = 3'b010;
  localparam logic [2:0] OP_ALU3 = 3'b011;
  localparam logic [2:0] OP_LOAD = 3'b100;
  localparam logic [2:0] OP_CMP  = 3'b101;
  localparam logic [2:0] OP_LOOP = 3'b110;
  localparam logic [2:0] OP_HALT = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/fsm_ctrl_unit_if.sv
// Program-store fetch bus: valid/ready instruction handshake plus fetch address.
interface fsm_ctrl_unit_if #(
  parameter int OPW = 3,
  parameter int AW  = 2,
  parameter int PCW = 4
);
  localparam int IW = OPW + 2 * AW;

  logic          instr_valid;
  logic [IW-1:0] instr;
  logic          instr_ready;
  logic [PCW-1:0] pc;

  modport master (input instr_valid, input instr, output instr_ready, output pc);
  modport slave  (output instr_valid, output instr, input instr_ready, input pc);
endinterface

// File: rtl/fsm_ctrl_decode.sv
// Combinational instruction decode: IR fields and write/load/loop/halt flags.
// FSM_CTRL_LOOP_EN enables the LOOP opcode; otherwise 110 decodes as NOP.
module fsm_ctrl_decode
  import fsm_ctrl_pkg::*;
#(
  parameter int OPW = 3,
  parameter int AW  = 2
) (
  input  logic [OPW+2*AW-1:0] ir,
  output logic [OPW-1:0]      alu_opcode,
  output logic [AW-1:0]       operand1,
  output logic [AW-1:0]       operand2,
  output logic                wr,
  output logic                load,
  output logic                loop,
  output logic                halt
);

  localparam int IW = OPW + 2 * AW;

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    alu_opcode = ir[IW-1 -: OPW];
    operand1   = ir[2*AW-1 -: AW];
    operand2   = ir[AW-1:0];
    wr         = 1'b0;
    load       = 1'b0;
    loop       = 1'b0;
    halt       = 1'b0;
    // Opcodes wider than 3 bits with any upper bit set fall to the NOP default.
    case (alu_opcode)
      OPW'(OP_ALU1), OPW'(OP_ALU2), OPW'(OP_ALU3): wr = 1'b1;
      OPW'(OP_LOAD): begin
        wr   = 1'b1;
        load = 1'b1;
      end
`ifdef FSM_CTRL_LOOP_EN
      OPW'(OP_LOOP): loop = 1'b1;
`endif
      OPW'(OP_HALT): halt = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/fsm_ctrl_unit.sv
// Fetch/execute controller: FSM, instruction register, pc and optional loop counter.
// FSM_CTRL_LOOP_EN adds the hardware loop counter and the LOOP instruction.
module fsm_ctrl_unit
  import fsm_ctrl_pkg::*;
#(
  parameter int OPW  = 3,
  parameter int AW   = 2,
  parameter int PCW  = 4,
  parameter int CNTW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [CNTW-1:0] loop_init,
  fsm_ctrl_unit_if.master bus,
  output logic [OPW-1:0]  alu_opcode,
  output logic [AW-1:0]   rd_addr1,
  output logic [AW-1:0]   wrt_addr,
  output logic [AW-1:0]   rd_addr2,
  output logic            wrt_en,
  output logic            load_data,
  output logic            busy,
  output logic            done
);

  localparam int IW = OPW + 2 * AW;

  state_e         state_q, state_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [IW-1:0]  ir_q, ir_d;
  logic [AW-1:0]  op1, op2;
  logic           dec_wr, dec_load, dec_loop, dec_halt;
  logic           cnt_nz;

`ifdef FSM_CTRL_LOOP_EN
  logic [CNTW-1:0] cnt_q, cnt_d;
  assign cnt_nz = (cnt_q != '0);
`else
  logic unused_loop_init;
  assign unused_loop_init = ^loop_init;
  assign cnt_nz           = 1'b0;
`endif

  fsm_ctrl_decode #(.OPW(OPW), .AW(AW)) u_decode (
    .ir         (ir_q),
    .alu_opcode (alu_opcode),
    .operand1   (op1),
    .operand2   (op2),
    .wr         (dec_wr),
    .load       (dec_load),
    .loop       (dec_loop),
    .halt       (dec_halt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
`ifdef FSM_CTRL_LOOP_EN
    cnt_d   = cnt_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_d    = '0;
`ifdef FSM_CTRL_LOOP_EN
          cnt_d   = loop_init;
`endif
        end
      end
      ST_FETCH: begin
        if (bus.instr_valid) begin
          ir_d    = bus.instr;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (dec_halt) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
          // pc only moves on the EXEC exit edge so it names the instruction for both phases.
          if (dec_loop && cnt_nz) begin
            pc_d  = PCW'({op1, op2});
`ifdef FSM_CTRL_LOOP_EN
            cnt_d = cnt_q - 1'b1;
`endif
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
`ifdef FSM_CTRL_LOOP_EN
      cnt_q   <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
`ifdef FSM_CTRL_LOOP_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign rd_addr1        = op1;
  assign wrt_addr        = op1;
  assign rd_addr2        = op2;
  assign wrt_en          = (state_q == ST_EXEC) && dec_wr;
  assign load_data       = (state_q == ST_EXEC) && dec_load;
  assign busy            = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign done            = (state_q == ST_DONE);
  assign bus.instr_ready = (state_q == ST_FETCH);
  assign bus.pc          = pc_q;

endmodule

// File: tb/tb_fsm_ctrl_unit.sv
// Self-checking bench for fsm_ctrl_unit: decode table, directed timing sequences,
// and randomized programs checked against an instruction-level reference model.
module tb_fsm_ctrl_unit;
  import fsm_ctrl_pkg::*;

  localparam int OPW = 3, AW = 2, PCW = 4, CNTW = 8;
  localparam int IW = OPW + 2 * AW;
`ifdef FSM_CTRL_LOOP_EN
  localparam bit LOOP_EN = 1'b1;
`else
  localparam bit LOOP_EN = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] pc;
    logic [2:0] op;
    logic       wr;
    logic       ld;
  } rec_t;

  typedef struct {
    logic [6:0] instr;
    logic [2:0] op;
    logic [1:0] a1;
    logic [1:0] a2;
    logic       wr;
    logic       ld;
    logic [3:0] end_pc;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [CNTW-1:0] loop_init;
  logic            valid_drv;
  logic [IW-1:0]   prog [16];
  logic [OPW-1:0]  alu_opcode;
  logic [AW-1:0]   rd_addr1, wrt_addr, rd_addr2;
  logic            wrt_en, load_data, busy, done;

  int total = 0;
  int bad   = 0;
  rec_t got_q[$];
  rec_t exp_q[$];
  vec_t vecs[8];

  always #5 clk = ~clk;

  fsm_ctrl_unit_if #(.OPW(OPW), .AW(AW), .PCW(PCW)) bus ();
  assign bus.instr_valid = valid_drv;
  assign bus.instr       = prog[bus.pc];

  fsm_ctrl_unit #(.OPW(OPW), .AW(AW), .PCW(PCW), .CNTW(CNTW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .loop_init  (loop_init),
    .bus        (bus.master),
    .alu_opcode (alu_opcode),
    .rd_addr1   (rd_addr1),
    .wrt_addr   (wrt_addr),
    .rd_addr2   (rd_addr2),
    .wrt_en     (wrt_en),
    .load_data  (load_data),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse_start(input logic [CNTW-1:0] li);
    loop_init = li;
    start     = 1'b1;
    cyc();
    start     = 1'b0;
  endtask

  function automatic logic in_exec();
    return busy && !bus.instr_ready;
  endfunction

  // Records every executed instruction until done, optionally with random fetch stalls.
  task automatic run_to_done(input int budget, input bit rand_valid);
    int   n    = 0;
    int   serr = 0;
    rec_t r;
    got_q.delete();
    while (!done && n < budget) begin
      if (in_exec()) begin
        r.pc = bus.pc; r.op = alu_opcode; r.wr = wrt_en; r.ld = load_data;
        got_q.push_back(r);
      end else if (wrt_en || load_data) begin
        serr++;
      end
      if (rand_valid) valid_drv = ($urandom_range(0, 3) != 0);
      cyc();
      n++;
    end
    valid_drv = 1'b1;
    check("run_reaches_done", 32'(done), 32'd1);
    check("strobe_outside_exec", 32'(serr), 32'd0);
  endtask

  // Instruction-level ISA model of the program in prog[].
  task automatic model_run(input logic [CNTW-1:0] li);
    int         p     = 0;
    int         c     = int'(li);
    int         steps = 0;
    logic [6:0] w;
    rec_t       r;
    exp_q.delete();
    while (steps < 1000) begin
      w    = prog[p];
      r.pc = 4'(p);
      r.op = w[6:4];
      r.wr = (w[6:4] >= 3'd1) && (w[6:4] <= 3'd4);
      r.ld = (w[6:4] == 3'd4);
      exp_q.push_back(r);
      steps++;
      if (w[6:4] == 3'd7) break;
      if (w[6:4] == 3'd6 && LOOP_EN && c > 0) begin
        c--;
        p = int'(w[3:0]);
      end else begin
        p = (p + 1) % 16;
      end
    end
  endtask

  task automatic compare_trace(input string name);
    int n;
    check({name, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({name, "_rec"}, 32'(got_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) prog[i] = 7'b000_00_00;
  endtask

  initial begin
    logic [7:0] wm, lm, dm;
    int         ok, body;
    logic [CNTW-1:0] li;

    vecs[0] = '{7'b000_11_01, 3'd0, 2'd3, 2'd1, 1'b0, 1'b0, 4'd1};
    vecs[1] = '{7'b001_01_10, 3'd1, 2'd1, 2'd2, 1'b1, 1'b0, 4'd1};
    vecs[2] = '{7'b010_10_11, 3'd2, 2'd2, 2'd3, 1'b1, 1'b0, 4'd1};
    vecs[3] = '{7'b011_11_00, 3'd3, 2'd3, 2'd0, 1'b1, 1'b0, 4'd1};
    vecs[4] = '{7'b100_00_11, 3'd4, 2'd0, 2'd3, 1'b1, 1'b1, 4'd1};
    vecs[5] = '{7'b101_10_01, 3'd5, 2'd2, 2'd1, 1'b0, 1'b0, 4'd1};
    vecs[6] = '{7'b110_11_10, 3'd6, 2'd3, 2'd2, 1'b0, 1'b0, 4'd1};
    vecs[7] = '{7'b111_01_01, 3'd7, 2'd1, 2'd1, 1'b0, 1'b0, 4'd0};

    rst = 1'b1; start = 1'b0; loop_init = '0; valid_drv = 1'b1;
    clear_prog();
    cyc(); cyc();
    check("reset_outputs", 32'({alu_opcode, rd_addr1, wrt_addr, rd_addr2, wrt_en, load_data,
                                busy, done, bus.instr_ready, bus.pc}), 32'd0);
    rst = 1'b0;
    cyc();
    check("idle_after_reset", 32'({busy, done, bus.instr_ready}), 32'd0);

    // Three-instruction program with no stalls.
    prog[0] = 7'b100_00_00; prog[1] = 7'b001_01_00; prog[2] = 7'b111_00_00;
    pulse_start('0);
    wm = '0; lm = '0; dm = '0;
    for (int c = 1; c <= 7; c++) begin
      wm[c] = wrt_en; lm[c] = load_data; dm[c] = done;
      cyc();
    end
    check("seq_wrt_en_cycles", 32'(wm), 32'h14);
    check("seq_load_cycles", 32'(lm), 32'h04);
    check("seq_done_cycles", 32'(dm), 32'h80);

    // Reset during EXEC of LOAD aborts with no strobe.
    clear_prog();
    prog[0] = 7'b100_01_10;
    pulse_start('0);
    cyc();
    check("rmid_exec_strobes", 32'({wrt_en, load_data, rd_addr1, rd_addr2}), 32'b11_01_10);
    rst = 1'b1;
    cyc();
    check("rmid_outputs_zero", 32'({alu_opcode, rd_addr1, wrt_addr, rd_addr2, wrt_en, load_data,
                                    busy, done, bus.instr_ready, bus.pc}), 32'd0);
    rst = 1'b0;
    cyc();
    check("rmid_idle", 32'({busy, done}), 32'd0);

    // Fetch stall for five cycles, accept on the sixth.
    clear_prog();
    prog[0] = 7'b001_10_11; prog[1] = 7'b111_00_00;
    valid_drv = 1'b0;
    pulse_start('0);
    ok = 0;
    for (int c = 1; c <= 5; c++) begin
      if (bus.instr_ready && bus.pc == 4'd0 && !wrt_en && !load_data && busy) ok++;
      cyc();
    end
    check("stall_hold_cycles", 32'(ok), 32'd5);
    check("stall_ready_6th", 32'(bus.instr_ready), 32'd1);
    valid_drv = 1'b1;
    cyc();
    check("stall_exec_next", 32'({in_exec(), wrt_en, rd_addr1, rd_addr2}), 32'b1_1_10_11);
    run_to_done(100, 1'b0);

    // Decode table: one instruction then HALT.
    for (int v = 0; v < 8; v++) begin
      clear_prog();
      prog[0] = vecs[v].instr; prog[1] = 7'b111_00_00;
      pulse_start('0);
      cyc();
      check($sformatf("dec%0d_fields", v),
            32'({alu_opcode, rd_addr1, wrt_addr, rd_addr2, wrt_en, load_data}),
            32'({vecs[v].op, vecs[v].a1, vecs[v].a1, vecs[v].a2, vecs[v].wr, vecs[v].ld}));
      run_to_done(100, 1'b0);
      check($sformatf("dec%0d_end_pc", v), 32'(bus.pc), 32'(vecs[v].end_pc));
    end

    // LOOP back to pc 1 with count 3.
    clear_prog();
    prog[1] = 7'b001_00_00; prog[2] = 7'b110_00_01; prog[3] = 7'b111_00_00;
    pulse_start(8'd3);
    run_to_done(200, 1'b0);
    body = 0;
    foreach (got_q[i]) if (got_q[i].pc == 4'd1) body++;
    check("loop_body_count", 32'(body), LOOP_EN ? 32'd4 : 32'd1);
    check("loop_final_pc", 32'(bus.pc), 32'd3);
    model_run(8'd3);
    compare_trace("loop_trace");

    // pc wrap 15 -> 0 with HALT found at pc 0 on the second pass; start ignored while busy.
    clear_prog();
    pulse_start('0);
    cyc();
    prog[0] = 7'b111_00_00;
    start = 1'b1;
    cyc(); cyc(); cyc();
    start = 1'b0;
    check("start_ignored_busy", 32'({busy, bus.pc}), 32'b1_0010);
    run_to_done(200, 1'b0);
    check("wrap_len", 32'(got_q.size()), 32'd15);
    if (got_q.size() == 15) begin
      check("wrap_pc15", 32'(got_q[13].pc), 32'd15);
      check("wrap_halt_pc0", 32'({got_q[14].pc, got_q[14].op}), 32'b0000_111);
    end
    check("wrap_done_pc", 32'({done, busy, bus.pc}), 32'b1_0_0000);
    pulse_start('0);
    check("restart_from_done", 32'({done, bus.instr_ready, bus.pc}), 32'b0_1_0000);
    run_to_done(200, 1'b0);

    // Randomized programs with random fetch stalls.
    for (int t = 0; t < 25; t++) begin
      for (int i = 0; i < 15; i++) begin
        prog[i] = 7'($urandom_range(0, 127));
        if (prog[i][6:4] == 3'd7 && $urandom_range(0, 3) != 0) prog[i][6:4] = 3'd1;
      end
      prog[15] = 7'b111_00_00;
      li = CNTW'($urandom_range(0, 5));
      model_run(li);
      pulse_start(li);
      run_to_done(3000, 1'b1);
      compare_trace($sformatf("rand%0d", t));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
